full_sram_seq: RTL and testbench

Synchronous access sequencer that drives the `full_sram` custom macro from a simple valid/ready request port. It decodes a 10-bit address into the macro's 1024 one-hot wordlines and generates the precharge → wordline/enable → recover sequence. It registers write data and captures read data from the macro outputs. It sits between the user-project bus logic and the `full_sram` instance; the macro itself is a blackbox.

---
 rtl/full_sram_seq.sv | 123 ++++++++++++
 tb/tb_full_sram_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_sram_seq.sv
// Access sequencer for the full_sram macro: turns a valid/ready request into a
// precharge -> wordline/enable -> recover sequence and captures read data.
module full_sram_seq #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int PRE_CYCLES = 1,
    parameter int ACC_CYCLES = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    input  logic [DATA_W-1:0]        req_wdata_i,
    output logic                     resp_valid_o,
    output logic [DATA_W-1:0]        resp_rdata_o,
    output logic                     sram_pre_o,
    output logic                     sram_readen_o,
    output logic                     sram_writeen_o,
    output logic [(1<<ADDR_W)-1:0]   sram_wl_o,
    output logic [DATA_W-1:0]        sram_din_o,
    input  logic [DATA_W-1:0]        sram_dout_i
);

    localparam int CNT_MAX = (PRE_CYCLES > ACC_CYCLES) ? PRE_CYCLES : ACC_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACCESS    = 2'd2,
        RECOVER   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [(1<<ADDR_W)-1:0] wl_dec;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The counter is reloaded on each phase entry and the phase ends when it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    wdata_d = req_we_i ? req_wdata_i : wdata_q;
                    cnt_d   = PRE_LOAD;
                    state_d = PRECHARGE;
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    cnt_d   = ACC_LOAD;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Read data is sampled at the edge closing the last access cycle.
                    if (!we_q) rdata_d = sram_dout_i;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wl_dec = '0;
        if (state_q == ACCESS) wl_dec[addr_q] = 1'b1;
    end

    // All macro controls decode from registered state, so reset clears them at once.
    assign req_ready_o    = (state_q == IDLE);
    assign resp_valid_o   = (state_q == RECOVER);
    assign sram_pre_o     = (state_q != ACCESS);
    assign sram_readen_o  = (state_q == ACCESS) && !we_q;
    assign sram_writeen_o = (state_q == ACCESS) && we_q;
    assign sram_wl_o      = wl_dec;
    assign sram_din_o     = wdata_q;
    assign resp_rdata_o   = rdata_q;

endmodule

// File: tb/tb_full_sram_seq.sv
// Bench for full_sram_seq: default-parameter instance for directed scenarios and a
// PRE_CYCLES=3/ACC_CYCLES=1 instance for random traffic, each with a macro model.
module tb_full_sram_seq;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT a: default parameters ----------------
  logic          a_valid = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ready, a_resp_valid, a_pre, a_rden, a_wren;
  logic [DW-1:0] a_rdata, a_din, a_dout;
  logic [N-1:0]  a_wl;

  full_sram_seq u_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata),
    .resp_valid_o(a_resp_valid), .resp_rdata_o(a_rdata),
    .sram_pre_o(a_pre), .sram_readen_o(a_rden), .sram_writeen_o(a_wren),
    .sram_wl_o(a_wl), .sram_din_o(a_din), .sram_dout_i(a_dout)
  );

  // ---------------- DUT b: PRE=3, ACC=1 ----------------
  logic          b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ready, b_resp_valid, b_pre, b_rden, b_wren;
  logic [DW-1:0] b_rdata, b_din, b_dout;
  logic [N-1:0]  b_wl;

  full_sram_seq #(.ADDR_W(AW), .DATA_W(DW), .PRE_CYCLES(3), .ACC_CYCLES(1)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .resp_valid_o(b_resp_valid), .resp_rdata_o(b_rdata),
    .sram_pre_o(b_pre), .sram_readen_o(b_rden), .sram_writeen_o(b_wren),
    .sram_wl_o(b_wl), .sram_din_o(b_din), .sram_dout_i(b_dout)
  );

  // ---------------- macro models ----------------
  function automatic int wl_index(input logic [N-1:0] wl);
    for (int i = 0; i < N; i++) if (wl[i]) return i;
    return 0;
  endfunction

  function automatic logic [DW-1:0] seed(input int i);
    if (i == N - 1) return 32'hA5A5_0F0F;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  bit            a_wr [N];
  logic [DW-1:0] a_mem [N];
  int            a_idx;
  assign a_idx  = wl_index(a_wl);
  assign a_dout = a_rden ? (a_wr[a_idx] ? a_mem[a_idx] : seed(a_idx)) : 32'h0BAD_0BAD;
  always @(posedge clk) if (a_wren) begin
    a_mem[a_idx] <= a_din;
    a_wr[a_idx]  <= 1'b1;
  end

  bit            b_wr [N];
  logic [DW-1:0] b_mem [N];
  int            b_idx;
  assign b_idx  = wl_index(b_wl);
  assign b_dout = b_rden ? (b_wr[b_idx] ? b_mem[b_idx] : seed(b_idx)) : 32'h0BAD_0BAD;
  always @(posedge clk) if (b_wren) begin
    b_mem[b_idx] <= b_din;
    b_wr[b_idx]  <= 1'b1;
  end

  // ---------------- scoreboards ----------------
  logic [DW-1:0] a_ref [N];
  logic [DW-1:0] b_ref [N];
  logic [DW-1:0] a_exp_q [$];
  logic [DW-1:0] b_exp_q [$];
  int            a_acc_q [$];
  int            b_acc_q [$];
  logic [DW-1:0] a_last_rd = '0;
  logic [DW-1:0] b_last_rd = '0;
  int            a_last_acc, b_last_acc;

  always @(negedge clk) if (!rst) begin
    logic [DW-1:0] e;
    int c;
    n_checks++;
    if (a_pre && (|a_wl)) begin n_fail++; $display("FAIL a_inv_pre_wl: pre=%b wl_count=%0d cycle %0d", a_pre, $countones(a_wl), cyc); end
    n_checks++;
    if (a_rden && a_wren) begin n_fail++; $display("FAIL a_inv_en: readen=%b writeen=%b expected not both 1, cycle %0d", a_rden, a_wren, cyc); end
    n_checks++;
    if ((a_rden || a_wren) && ($countones(a_wl) != 1)) begin n_fail++; $display("FAIL a_inv_onehot: wl_count=%0d expected 1 with enable, cycle %0d", $countones(a_wl), cyc); end
    if (a_resp_valid) begin
      n_checks++;
      if (a_exp_q.size() == 0) begin
        n_fail++; $display("FAIL a_unexpected_resp: resp_valid=1 with 0 outstanding, expected 0, cycle %0d", cyc);
      end else begin
        e = a_exp_q.pop_front();
        c = a_acc_q.pop_front();
        if (a_rdata !== e) begin n_fail++; $display("FAIL a_rdata: got %h expected %h cycle %0d", a_rdata, e, cyc); end
        n_checks++;
        if (cyc - c != 4) begin n_fail++; $display("FAIL a_latency: got %0d expected 4", cyc - c); end
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    logic [DW-1:0] e;
    int c;
    n_checks++;
    if (b_pre && (|b_wl)) begin n_fail++; $display("FAIL b_inv_pre_wl: pre=%b wl_count=%0d cycle %0d", b_pre, $countones(b_wl), cyc); end
    n_checks++;
    if (b_rden && b_wren) begin n_fail++; $display("FAIL b_inv_en: readen=%b writeen=%b expected not both 1, cycle %0d", b_rden, b_wren, cyc); end
    n_checks++;
    if ((b_rden || b_wren) && ($countones(b_wl) != 1)) begin n_fail++; $display("FAIL b_inv_onehot: wl_count=%0d expected 1 with enable, cycle %0d", $countones(b_wl), cyc); end
    if (b_resp_valid) begin
      n_checks++;
      if (b_exp_q.size() == 0) begin
        n_fail++; $display("FAIL b_unexpected_resp: resp_valid=1 with 0 outstanding, expected 0, cycle %0d", cyc);
      end else begin
        e = b_exp_q.pop_front();
        c = b_acc_q.pop_front();
        if (b_rdata !== e) begin n_fail++; $display("FAIL b_rdata: got %h expected %h cycle %0d", b_rdata, e, cyc); end
        n_checks++;
        if (cyc - c != 5) begin n_fail++; $display("FAIL b_latency: got %0d expected 5", cyc - c); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request, waits for the handshake, records the expectation and
  // returns #1 after the accept edge (start of cycle 1) with valid still high.
  task automatic a_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int k = 0;
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    do begin @(negedge clk); k++; end while (!a_ready && k < 100);
    n_checks++;
    if (!a_ready) begin
      n_fail++; $display("FAIL a_accept_timeout: ready=%b expected 1 within 100 cycles", a_ready);
    end else begin
      a_acc_q.push_back(cyc);
      a_last_acc = cyc;
      if (we) a_ref[addr] = data;
      else    a_last_rd = a_ref[addr];
      a_exp_q.push_back(a_last_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic b_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int k = 0;
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    do begin @(negedge clk); k++; end while (!b_ready && k < 100);
    n_checks++;
    if (!b_ready) begin
      n_fail++; $display("FAIL b_accept_timeout: ready=%b expected 1 within 100 cycles", b_ready);
    end else begin
      b_acc_q.push_back(cyc);
      b_last_acc = cyc;
      if (we) b_ref[addr] = data;
      else    b_last_rd = b_ref[addr];
      b_exp_q.push_back(b_last_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic a_wait_done();
    int k = 0;
    while (a_exp_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (a_exp_q.size() != 0) begin n_fail++; $display("FAIL a_resp_timeout: outstanding=%0d expected 0", a_exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic b_wait_done();
    int k = 0;
    while (b_exp_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (b_exp_q.size() != 0) begin n_fail++; $display("FAIL b_resp_timeout: outstanding=%0d expected 0", b_exp_q.size()); end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (a_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_ready: got %b expected 1", a_ready); end
    n_checks++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", a_resp_valid); end
    n_checks++; if (a_rdata !== '0)       begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", a_rdata); end
    n_checks++; if (a_pre !== 1'b1)       begin n_fail++; $display("FAIL rst_pre: got %b expected 1", a_pre); end
    n_checks++; if (a_rden !== 1'b0)      begin n_fail++; $display("FAIL rst_readen: got %b expected 0", a_rden); end
    n_checks++; if (a_wren !== 1'b0)      begin n_fail++; $display("FAIL rst_writeen: got %b expected 0", a_wren); end
    n_checks++; if (a_wl !== '0)          begin n_fail++; $display("FAIL rst_wl: got count %0d expected 0", $countones(a_wl)); end
    n_checks++; if (a_din !== '0)         begin n_fail++; $display("FAIL rst_din: got %h expected 0", a_din); end
    n_checks++; if (b_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_b_ready: got %b expected 1", b_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [N-1:0] exp_wl = '0;
    exp_wl[5] = 1'b1;
    a_req(1'b1, 10'h005, 32'hDEAD_BEEF);
    a_valid = 1'b0;
    n_checks++; if (a_pre !== 1'b1) begin n_fail++; $display("FAIL wr_c1_pre: got %b expected 1", a_pre); end
    n_checks++; if (a_wren !== 1'b0) begin n_fail++; $display("FAIL wr_c1_writeen: got %b expected 0", a_wren); end
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (a_wl !== exp_wl) begin n_fail++; $display("FAIL wr_c%0d_wl: got idx %0d count %0d expected idx 5 count 1", c, wl_index(a_wl), $countones(a_wl)); end
      n_checks++; if (a_wren !== 1'b1 || a_rden !== 1'b0) begin n_fail++; $display("FAIL wr_c%0d_en: got we=%b re=%b expected we=1 re=0", c, a_wren, a_rden); end
      n_checks++; if (a_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_c%0d_din: got %h expected deadbeef", c, a_din); end
      n_checks++; if (a_pre !== 1'b0) begin n_fail++; $display("FAIL wr_c%0d_pre: got %b expected 0", c, a_pre); end
    end
    @(posedge clk); #1;
    n_checks++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_c4_resp_valid: got %b expected 1", a_resp_valid); end
    n_checks++; if (a_wl !== '0 || a_wren !== 1'b0) begin n_fail++; $display("FAIL wr_c4_idle_macro: got wl_count %0d we=%b expected 0 0", $countones(a_wl), a_wren); end
    @(posedge clk); #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL wr_c5_ready: got %b expected 1", a_ready); end
    n_checks++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_c5_resp_valid: got %b expected 0", a_resp_valid); end
  endtask

  task automatic test_read();
    logic [N-1:0] exp_wl = '0;
    exp_wl[N-1] = 1'b1;
    a_req(1'b0, 10'h3FF, 32'h0);
    a_valid = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (a_wl !== exp_wl) begin n_fail++; $display("FAIL rd_c%0d_wl: got idx %0d count %0d expected idx 1023 count 1", c, wl_index(a_wl), $countones(a_wl)); end
      n_checks++; if (a_rden !== 1'b1 || a_wren !== 1'b0) begin n_fail++; $display("FAIL rd_c%0d_en: got re=%b we=%b expected re=1 we=0", c, a_rden, a_wren); end
    end
    @(posedge clk); #1;
    n_checks++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_c4_resp_valid: got %b expected 1", a_resp_valid); end
    n_checks++; if (a_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL rd_c4_rdata: got %h expected a5a50f0f", a_rdata); end
    n_checks++; if (a_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_din_hold: got %h expected deadbeef", a_din); end
    a_wait_done();
  endtask

  task automatic test_back_to_back();
    int c0;
    a_req(1'b1, 10'h000, 32'h1234_5678);
    c0 = a_last_acc;
    a_req(1'b0, 10'h000, 32'hFFFF_FFFF);
    a_valid = 1'b0;
    n_checks++; if (a_last_acc - c0 != 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 5", a_last_acc - c0); end
    a_wait_done();
    n_checks++; if (a_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_rdata: got %h expected 12345678", a_rdata); end
    n_checks++; if (a_din !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_din_hold: got %h expected 12345678", a_din); end
  endtask

  task automatic test_reset_mid_write();
    a_req(1'b1, 10'h007, 32'hCAFE_F00D);
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (a_wren !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset_writeen: got %b expected 1", a_wren); end
    rst = 1'b1;
    a_exp_q.delete();
    a_acc_q.delete();
    a_last_rd = '0;
    #1;
    n_checks++; if (a_wl !== '0)        begin n_fail++; $display("FAIL mid_wl: got count %0d expected 0", $countones(a_wl)); end
    n_checks++; if (a_wren !== 1'b0)    begin n_fail++; $display("FAIL mid_writeen: got %b expected 0", a_wren); end
    n_checks++; if (a_pre !== 1'b1)     begin n_fail++; $display("FAIL mid_pre: got %b expected 1", a_pre); end
    n_checks++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_resp_valid: got %b expected 0", a_resp_valid); end
    n_checks++; if (a_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_ready: got %b expected 1", a_ready); end
    n_checks++; if (a_din !== '0)       begin n_fail++; $display("FAIL mid_din: got %h expected 0", a_din); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    a_req(1'b0, 10'h000, 32'h0);
    a_valid = 1'b0;
    a_wait_done();
    n_checks++; if (a_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_next_rdata: got %h expected 12345678", a_rdata); end
  endtask

  task automatic test_random();
    int start = cyc;
    int gap;
    while (cyc - start < 10000) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        b_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      b_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)), $urandom);
    end
    b_valid = 1'b0;
    b_wait_done();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_ref[i] = seed(i);
      b_ref[i] = seed(i);
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
